// File: rtl/mul_accumulate.sv
// -----------------------------------------------------------------------------
// mul_accumulate
//
// Dot-product accumulator placed after the pipelined signed multiplier.
// Sums VECTOR_LEN valid products into a signed running sum and reports the
// result, together with a sticky signed-overflow flag, one cycle after the
// final product of each vector. Back-to-back vectors stream with no bubble.
// in_clear aborts a partial vector; reset discards it as well.
//
// Optional build macro:
//   MUL_ACC_SATURATE_EN - when defined, the running sum clamps to the signed
//                         ACC_WIDTH limits on overflow instead of wrapping.
//                         Overflow reporting is the same in both builds.
// -----------------------------------------------------------------------------
module mul_accumulate #(
    parameter int P_WIDTH    = 9,
    parameter int VECTOR_LEN = 4,
    parameter int ACC_WIDTH  = P_WIDTH + $clog2(VECTOR_LEN)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic signed [P_WIDTH-1:0]   in_C,
    input  logic                        in_clear,
    output logic                        out_valid,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic                        out_overflow
);

    // Count needs at least one bit, even for single-product vectors.
    localparam int CNT_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;

    // Count value at which the next valid product completes the vector.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VECTOR_LEN - 1);

    // Signed limits of the accumulator, used by the clamping build.
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // A sum carried in ACC_WIDTH+1 bits has left the signed ACC_WIDTH range
    // exactly when its two most significant bits disagree.
    function automatic logic add_overflow(input logic [ACC_WIDTH:0] s);
        return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
    endfunction

    // Reduce the widened sum back to ACC_WIDTH bits: either two's-complement
    // wrap, or clamp toward the side the true result went (the extra top bit
    // is the true sign of the widened sum).
    function automatic logic signed [ACC_WIDTH-1:0] fit_acc(input logic [ACC_WIDTH:0] s);
        logic signed [ACC_WIDTH-1:0] r;
        r = s[ACC_WIDTH-1:0];
`ifdef MUL_ACC_SATURATE_EN
        if (add_overflow(s)) begin
            r = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
`endif
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                       state_q,     state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q,       acc_d;
    logic        [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                         flag_q,      flag_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0]  out_sum_q,   out_sum_d;
    logic                         out_ovf_q,   out_ovf_d;

    // Adder operands and result
    logic        [ACC_WIDTH:0]    acc_base_w;
    logic        [ACC_WIDTH:0]    prod_ext_w;
    logic        [ACC_WIDTH:0]    sum_w;
    logic                         add_ovf_w;
    logic signed [ACC_WIDTH-1:0]  acc_next_w;

    // Widened adder: in IDLE the running sum is zero by definition, so a new
    // vector always starts from a clean base.
    always_comb begin
        acc_base_w = '0;
        if (state_q == ACCUM) begin
            acc_base_w = {acc_q[ACC_WIDTH-1], acc_q};
        end
        prod_ext_w = {{(ACC_WIDTH + 1 - P_WIDTH){in_C[P_WIDTH-1]}}, in_C};
        sum_w      = acc_base_w + prod_ext_w;
        add_ovf_w  = add_overflow(sum_w);
        acc_next_w = fit_acc(sum_w);
    end

    // Next-state and output logic: clear beats valid; a product at the last
    // count completes the vector and returns everything to IDLE.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (in_clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            flag_d  = 1'b0;
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (LAST_CNT == '0) begin
                        // Single-product vectors complete straight from IDLE.
                        out_valid_d = 1'b1;
                        out_sum_d   = acc_next_w;
                        out_ovf_d   = add_ovf_w;
                        acc_d       = '0;
                        cnt_d       = '0;
                        flag_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        acc_d   = acc_next_w;
                        cnt_d   = CNT_W'(1);
                        flag_d  = add_ovf_w;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (cnt_q == LAST_CNT) begin
                        out_valid_d = 1'b1;
                        out_sum_d   = acc_next_w;
                        out_ovf_d   = flag_q | add_ovf_w;
                        acc_d       = '0;
                        cnt_d       = '0;
                        flag_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        acc_d   = acc_next_w;
                        cnt_d   = cnt_q + 1'b1;
                        flag_d  = flag_q | add_ovf_w;
                        state_d = ACCUM;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset discards any partial vector and
    // returns all outputs to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_mul_accumulate.sv
// -----------------------------------------------------------------------------
// tb_mul_accumulate
//
// Drives two accumulators with a shared product stream: one with default
// widths (ACC_WIDTH=11) and one with ACC_WIDTH=10 so overflow is reachable.
// The expected results come from a vector-level model: products of the
// current vector are queued, and on completion the queue is summed with
// plain integer arithmetic, applying wrap or clamp per add.
// -----------------------------------------------------------------------------
module tb_mul_accumulate;

    localparam int P_W  = 9;
    localparam int VLEN = 4;
    localparam int AW_W = 11;
    localparam int AW_N = 10;

    logic                    clk;
    logic                    reset;
    logic                    in_valid;
    logic signed [P_W-1:0]   in_C;
    logic                    in_clear;

    logic                    w_valid;
    logic signed [AW_W-1:0]  w_sum;
    logic                    w_ovf;
    logic                    n_valid;
    logic signed [AW_N-1:0]  n_sum;
    logic                    n_ovf;

    int checks = 0;
    int errors = 0;

    // Model state
    int     prods[$];
    bit     exp_v;
    longint exp_sw, exp_sn;
    bit     exp_ow, exp_on;

    mul_accumulate #(.P_WIDTH(P_W), .VECTOR_LEN(VLEN), .ACC_WIDTH(AW_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_C(in_C), .in_clear(in_clear),
        .out_valid(w_valid), .out_sum(w_sum), .out_overflow(w_ovf)
    );

    mul_accumulate #(.P_WIDTH(P_W), .VECTOR_LEN(VLEN), .ACC_WIDTH(AW_N)) dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_C(in_C), .in_clear(in_clear),
        .out_valid(n_valid), .out_sum(n_sum), .out_overflow(n_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Sum the queued vector in an accumulator of width aw.
    function automatic void eval_vec(input int aw, output longint s, output bit o);
        longint one, hi, lo, m, r, t;
        one = 1;
        hi  = (one << (aw - 1)) - 1;
        lo  = -(one << (aw - 1));
        m   = one << aw;
        r   = 0;
        o   = 1'b0;
        foreach (prods[i]) begin
            t = r + longint'(prods[i]);
            if (t > hi || t < lo) begin
                o = 1'b1;
`ifdef MUL_ACC_SATURATE_EN
                r = (t > hi) ? hi : lo;
`else
                r = (((t - lo) % m) + m) % m + lo;
`endif
            end else begin
                r = t;
            end
        end
        s = r;
    endfunction

    // One clock: apply inputs, advance the model, then compare both DUTs.
    task automatic tick(input bit rst, input bit v, input bit clr, input int c);
        reset    = rst;
        in_valid = v;
        in_clear = clr;
        in_C     = P_W'(c);
        if (rst) begin
            prods.delete();
            exp_v  = 1'b0;
            exp_sw = 0;
            exp_sn = 0;
            exp_ow = 1'b0;
            exp_on = 1'b0;
        end else if (clr) begin
            prods.delete();
            exp_v = 1'b0;
        end else if (v) begin
            prods.push_back(c);
            if (prods.size() == VLEN) begin
                exp_v = 1'b1;
                eval_vec(AW_W, exp_sw, exp_ow);
                eval_vec(AW_N, exp_sn, exp_on);
                prods.delete();
            end else begin
                exp_v = 1'b0;
            end
        end else begin
            exp_v = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("w_valid", longint'(w_valid), longint'(exp_v));
        chk("w_sum",   longint'(w_sum),   exp_sw);
        chk("w_ovf",   longint'(w_ovf),   longint'(exp_ow));
        chk("n_valid", longint'(n_valid), longint'(exp_v));
        chk("n_sum",   longint'(n_sum),   exp_sn);
        chk("n_ovf",   longint'(n_ovf),   longint'(exp_on));
    endtask

    initial begin
        int r, c;
        bit v, clr, rst;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_C     = '0;
        in_clear = 1'b0;

        // Reset state
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_valid", longint'(w_valid), 0);
        chk("rst_sum",   longint'(w_sum),   0);

        // Four -90 products back to back, single-cycle pulse
        for (int i = 0; i < 4; i++) tick(0, 1, 0, -90);
        chk("tp1_valid", longint'(w_valid), 1);
        chk("tp1_sum",   longint'(w_sum),   -360);
        chk("tp1_ovf",   longint'(w_ovf),   0);
        tick(0, 0, 0, 0);
        chk("tp1_pulse_end", longint'(w_valid), 0);

        // Products with two-cycle gaps
        tick(0, 1, 0, -90); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 1, 0, 3);   tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 1, 0, 100); tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        tick(0, 1, 0, 7);
        chk("tp2_sum", longint'(w_sum), 20);
        tick(0, 0, 0, 0);

        // Back-to-back vectors
        tick(0, 1, 0, 1); tick(0, 1, 0, 2); tick(0, 1, 0, 3); tick(0, 1, 0, 4);
        chk("tp3_sum_a", longint'(w_sum), 10);
        tick(0, 1, 0, -1); tick(0, 1, 0, -2); tick(0, 1, 0, -3); tick(0, 1, 0, -4);
        chk("tp3_sum_b", longint'(w_sum), -10);
        tick(0, 0, 0, 0); tick(0, 0, 0, 0);
        chk("tp3_hold", longint'(w_sum), -10);

        // Clear with a same-cycle product
        tick(0, 1, 0, 5); tick(0, 1, 0, 6); tick(0, 1, 1, 9);
        tick(0, 1, 0, 1); tick(0, 1, 0, 1); tick(0, 1, 0, 1); tick(0, 1, 0, 1);
        chk("tp4_sum", longint'(w_sum), 4);
        tick(0, 0, 0, 0);

        // Overflow in the narrow accumulator
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 255);
`ifdef MUL_ACC_SATURATE_EN
        chk("tp5_n_sum", longint'(n_sum), 511);
`else
        chk("tp5_n_sum", longint'(n_sum), -4);
`endif
        chk("tp5_n_ovf", longint'(n_ovf), 1);
        chk("tp5_w_sum", longint'(w_sum), 1020);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 1);
        chk("tp5b_n_sum", longint'(n_sum), 4);
        chk("tp5b_n_ovf", longint'(n_ovf), 0);

        // Reset mid-vector, then the exact negative bound
        tick(0, 1, 0, 50); tick(0, 1, 0, 60);
        tick(1, 0, 0, 0);  tick(1, 0, 0, 0);
        chk("tp6_rst_sum", longint'(w_sum), 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, -256);
        chk("tp6_sum", longint'(w_sum), -1024);
        chk("tp6_ovf", longint'(w_ovf), 0);
        tick(0, 0, 0, 0);

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            r   = int'($urandom_range(0, 99));
            rst = (r < 2);
            clr = (r >= 2 && r < 7);
            v   = ($urandom_range(0, 9) < 7);
            c   = int'($urandom_range(0, 511)) - 256;
            tick(rst, v, clr, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
